// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART frame loader.
package uart_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM,
    S_WAIT
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_OVERRUN = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_BAD_CMD = 3'd4;

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: loadable down-counter, expires after TIMEOUT_CLKS
// enabled cycles without a reload.
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CLKS = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [23:0] RELOAD = 24'(TIMEOUT_CLKS - 1);

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = RELOAD;
    else if (en && cnt_q != 24'd0)
      cnt_d = cnt_q - 24'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  // Saturates at zero so an idle loader never sees a wrapped count.
  assign expired = en && (cnt_q == 24'd0);

endmodule

// File: rtl/uart_loader.sv
// Frame parser behind the UART receiver: writes payload to memory, checks
// the checksum and releases the system hold on a good RUN frame.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CLKS = 120000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_wr,
  input  logic                  mem_ack,
  output logic                  sys_hold,
  output logic                  done,
  output logic [2:0]            err_code
);

  state_e                state_q, state_d;
  logic                  rx_valid_q;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic                  is_run_q, is_run_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_data_q, mem_data_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  sys_hold_q, sys_hold_d;
  logic                  done_q, done_d;
  logic [2:0]            err_q, err_d;

  logic        accept, pending, expired;
  logic [7:0]  sum_next;
  logic [15:0] len_full;

  assign accept   = rx_valid && !rx_valid_q;
  assign pending  = mem_wr_q && !mem_ack;
  assign sum_next = sum_q + rx_byte;
  assign len_full = {len_q[15:8], rx_byte};

  uart_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .en      (state_q != S_IDLE),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    len_d      = len_q;
    sum_d      = sum_q;
    is_run_d   = is_run_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_d   = mem_wr_q;
    sys_hold_d = sys_hold_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (mem_wr_q && mem_ack) mem_wr_d = 1'b0;

    // Any in-flight write keeps going on timeout; only the frame is abandoned.
    if (expired && !accept) begin
      state_d = S_IDLE;
      err_d   = ERR_TIMEOUT;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept && rx_byte == SYNC_BYTE) begin
          state_d = S_CMD;
          err_d   = ERR_NONE;
        end
        S_CMD: if (accept) begin
          sum_d    = rx_byte;
          is_run_d = (rx_byte == CMD_RUN);
          if (rx_byte == CMD_WRITE) begin
            sys_hold_d = 1'b1;
            state_d    = S_ADDR_H;
          end else if (rx_byte == CMD_RUN) begin
            state_d = S_ADDR_H;
          end else begin
            err_d   = ERR_BAD_CMD;
            state_d = S_IDLE;
          end
        end
        S_ADDR_H: if (accept) begin
          addr_hi_d = rx_byte;
          sum_d     = sum_next;
          state_d   = S_ADDR_L;
        end
        S_ADDR_L: if (accept) begin
          addr_d  = ADDR_WIDTH'({addr_hi_q, rx_byte});
          sum_d   = sum_next;
          state_d = S_LEN_H;
        end
        S_LEN_H: if (accept) begin
          len_d   = {rx_byte, 8'h00};
          sum_d   = sum_next;
          state_d = S_LEN_L;
        end
        S_LEN_L: if (accept) begin
          len_d = len_full;
          sum_d = sum_next;
          if (is_run_q && len_full != 16'd0) begin
            err_d   = ERR_BAD_CMD;
            state_d = S_IDLE;
          end else begin
            state_d = (len_full == 16'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: if (accept) begin
          if (pending) begin
            err_d   = ERR_OVERRUN;
            state_d = S_IDLE;
          end else begin
            mem_wr_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = rx_byte;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            sum_d      = sum_next;
            len_d      = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: if (accept) begin
          if (sum_next != 8'h00) begin
            err_d   = ERR_CSUM;
            state_d = S_IDLE;
          end else if (pending) begin
            state_d = S_WAIT;
          end else begin
            done_d  = 1'b1;
            if (is_run_q) sys_hold_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          // Completion is reported only once the last payload byte is in memory.
          if (accept) begin
            err_d   = ERR_OVERRUN;
            state_d = S_IDLE;
          end else if (!pending) begin
            done_d  = 1'b1;
            if (is_run_q) sys_hold_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      is_run_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wr_q   <= 1'b0;
      sys_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      is_run_q   <= is_run_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_q   <= mem_wr_d;
      sys_hold_q <= sys_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wr   = mem_wr_q;
  assign sys_hold = sys_hold_q;
  assign done     = done_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frame table plus hand sequences for overrun,
// timeout, stretched strobes and mid-frame reset; writes go through a scoreboard.
module tb_uart_loader;
  import uart_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic        sys_hold;
  logic        done;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_WIDTH(16), .TIMEOUT_CLKS(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .mem_ack  (mem_ack),
    .sys_hold (sys_hold),
    .done     (done),
    .err_code (err_code)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] data;
    bit          bad;
    logic [2:0]  exp_err;
    int          exp_done;
    logic        exp_hold;
  } vec_t;

  wr_t  sb_q[$];
  wr_t  mon_w;
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  bit   ack_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the negedge so the DUT samples it at the next
  // posedge; each ack given is one completed write, checked against the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_wr && ack_en && !reset) begin
      mem_ack = 1'b1;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_data);
      end else begin
        mon_w = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
        chk("wr_data", 32'(mem_data), 32'(mon_w.data));
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  // Called on a negedge; strobe high for `hold` cycles, then one idle cycle.
  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_byte  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Checksum is derived from the sum rule (CMD..CSUM sums to zero).
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len,
                            input logic [31:0] data, input bit bad, input int hold);
    logic [7:0] sum;
    logic [7:0] b;
    sum = cmd + addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
    send_byte(SYNC_BYTE, hold);
    send_byte(cmd, hold);
    send_byte(addr[15:8], hold);
    send_byte(addr[7:0], hold);
    send_byte(len[15:8], hold);
    send_byte(len[7:0], hold);
    for (int i = 0; i < int'(len); i++) begin
      b = data[8*i +: 8];
      sum = sum + b;
      if (cmd == CMD_WRITE) sb_q.push_back('{addr + 16'(i), b});
      send_byte(b, hold);
    end
    b = 8'h00 - sum;
    if (bad) b = b + 8'h01;
    send_byte(b, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;

    vecs[0] = '{8'h01, 16'h8000, 16'd2, 32'h0000_2211, 1'b0, ERR_NONE,    1, 1'b1};
    vecs[1] = '{8'h02, 16'h0000, 16'd0, 32'h0000_0000, 1'b0, ERR_NONE,    1, 1'b0};
    vecs[2] = '{8'h01, 16'h8000, 16'd2, 32'h0000_2211, 1'b1, ERR_CSUM,    0, 1'b1};
    vecs[3] = '{8'h01, 16'hFFFF, 16'd3, 32'h00CC_BBAA, 1'b0, ERR_NONE,    1, 1'b1};
    vecs[4] = '{8'h01, 16'h4000, 16'd0, 32'h0000_0000, 1'b0, ERR_NONE,    1, 1'b1};
    vecs[5] = '{8'h02, 16'h0000, 16'd1, 32'h0000_005A, 1'b0, ERR_BAD_CMD, 0, 1'b1};
    vecs[6] = '{8'h07, 16'h0000, 16'd0, 32'h0000_0000, 1'b0, ERR_BAD_CMD, 0, 1'b1};
    vecs[7] = '{8'h02, 16'h0000, 16'd0, 32'h0000_0000, 1'b0, ERR_NONE,    1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_data", 32'(mem_data), 32'h0);
    chk("rst_mem_wr",   32'(mem_wr),   32'h0);
    chk("rst_sys_hold", 32'(sys_hold), 32'h1);
    chk("rst_done",     32'(done),     32'h0);
    chk("rst_err",      32'(err_code), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].bad, 1);
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_err", i),  32'(err_code), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_hold", i), 32'(sys_hold), 32'(vecs[i].exp_hold));
      chk($sformatf("v%0d_sb", i),   32'(sb_q.size()), 32'h0);
    end

    // RUN release timing: done and hold clear one cycle after CSUM accept.
    send_frame(CMD_WRITE, 16'h0100, 16'd1, 32'h99, 1'b0, 1);
    repeat (4) @(negedge clk);
    send_byte(SYNC_BYTE, 1);
    send_byte(CMD_RUN, 1);
    repeat (4) send_byte(8'h00, 1);
    chk("run_hold_before", 32'(sys_hold), 32'h1);
    chk("run_done_before", 32'(done), 32'h0);
    rx_byte  = 8'hFE;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("run_done_pulse", 32'(done), 32'h1);
    chk("run_hold_clear", 32'(sys_hold), 32'h0);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("run_done_one_cycle", 32'(done), 32'h0);
    repeat (4) @(negedge clk);

    // Overrun: second data byte lands while the first write is unacked.
    d0 = done_cnt;
    ack_en = 1'b0;
    send_byte(SYNC_BYTE, 1);
    send_byte(CMD_WRITE, 1);
    send_byte(8'h10, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    sb_q.push_back('{16'h1000, 8'h44});
    send_byte(8'h44, 1);
    repeat (3) @(negedge clk);
    chk("ovr_wr_held", 32'(mem_wr),   32'h1);
    chk("ovr_wr_addr", 32'(mem_addr), 32'h1000);
    chk("ovr_wr_data", 32'(mem_data), 32'h44);
    send_byte(8'h55, 1);
    chk("ovr_err", 32'(err_code), 32'(ERR_OVERRUN));
    chk("ovr_wr_still", 32'(mem_wr), 32'h1);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("ovr_wr_drop", 32'(mem_wr), 32'h0);
    chk("ovr_sb", 32'(sb_q.size()), 32'h0);
    chk("ovr_no_done", 32'(done_cnt - d0), 32'h0);

    // Timeout after ADDR_L with TIMEOUT_CLKS=100.
    send_byte(SYNC_BYTE, 1);
    send_byte(CMD_WRITE, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    repeat (98) @(negedge clk);
    chk("tmo_not_yet", 32'(err_code), 32'h0);
    @(negedge clk);
    chk("tmo_err", 32'(err_code), 32'(ERR_TIMEOUT));
    d0 = done_cnt;
    send_frame(CMD_RUN, 16'h0000, 16'd0, 32'h0, 1'b0, 1);
    repeat (4) @(negedge clk);
    chk("tmo_recover_err", 32'(err_code), 32'h0);
    chk("tmo_recover_done", 32'(done_cnt - d0), 32'h1);
    chk("tmo_recover_hold", 32'(sys_hold), 32'h0);

    // Stretched strobes: one accept per byte, stray byte ignored in IDLE.
    send_byte(8'h33, 2);
    send_byte(SYNC_BYTE, 2);
    send_byte(8'h07, 2);
    repeat (3) @(negedge clk);
    chk("hold2_badcmd", 32'(err_code), 32'(ERR_BAD_CMD));
    d0 = done_cnt;
    send_frame(CMD_WRITE, 16'h2000, 16'd2, 32'h7766, 1'b0, 3);
    repeat (4) @(negedge clk);
    chk("hold3_err", 32'(err_code), 32'h0);
    chk("hold3_done", 32'(done_cnt - d0), 32'h1);
    chk("hold3_sb", 32'(sb_q.size()), 32'h0);

    // Mid-frame reset drops the pending write.
    send_frame(CMD_RUN, 16'h0000, 16'd0, 32'h0, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("rst_pre_hold", 32'(sys_hold), 32'h0);
    ack_en = 1'b0;
    send_byte(SYNC_BYTE, 1);
    send_byte(CMD_WRITE, 1);
    send_byte(8'h30, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h88, 1);
    chk("midrst_wr_pending", 32'(mem_wr), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    chk("midrst_wr", 32'(mem_wr), 32'h0);
    chk("midrst_hold", 32'(sys_hold), 32'h1);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    repeat (6) @(negedge clk);
    chk("midrst_err", 32'(err_code), 32'h0);
    chk("midrst_sb", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
